// File: rtl/orange_pkg.sv
// Shared types and helpers for the orange zone classifier.
package orange_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACTIVE  = 3'd1,
    REPORT  = 3'd2,
    PUBLISH = 3'd3,
    WAIT    = 3'd4
  } state_t;

  localparam int DIR_NONE = 0;

  // Smallest w such that 2**w >= n; sizes counters holding values 0..n-1.
  function automatic int width_bits(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/orange_zone_classifier_argmax.sv
// zone_argmax: sequential max-finder, one zone per cycle, ties resolved to the lowest index.
module zone_argmax
  import orange_pkg::*;
#(
  parameter int NUM_ZONES = 3,
  parameter int CNT_W     = 17,
  localparam int IDX_W    = width_bits(NUM_ZONES)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             start,
  input  logic [NUM_ZONES-1:0][CNT_W-1:0]  counts,
  output logic                             done,
  output logic                             found,
  output logic [IDX_W-1:0]                 max_idx
);

  logic             busy_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] max_r;

  assign done = busy_r && (idx_r == IDX_W'(NUM_ZONES - 1));

  // Scan state: running maximum starts at zero so an all-zero frame reports nothing found.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r  <= 1'b0;
      idx_r   <= '0;
      max_r   <= '0;
      max_idx <= '0;
      found   <= 1'b0;
    end else if (start) begin
      busy_r  <= 1'b1;
      idx_r   <= '0;
      max_r   <= '0;
      max_idx <= '0;
      found   <= 1'b0;
    end else if (busy_r) begin
      if (counts[idx_r] > max_r) begin
        max_r   <= counts[idx_r];
        max_idx <= idx_r;
        found   <= 1'b1;
      end
      idx_r  <= idx_r + IDX_W'(1);
      busy_r <= !done;
    end
  end

endmodule

// File: rtl/orange_zone_classifier.sv
// Frame-level orange zone classifier: per-zone accumulation, argmax steering and area threshold.
// Optional build macro ORANGE_HYSTERESIS_EN adds two-frame hysteresis on orange_detected.
module orange_zone_classifier
  import orange_pkg::*;
#(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 240,
  parameter int NUM_ZONES     = 3,
  parameter int THRESHOLD_PCT = 25,
  localparam int CNT_W        = width_bits(WIDTH * HEIGHT + 1),
  localparam int DIR_W        = width_bits(NUM_ZONES + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             href,
  input  logic             vsync,
  input  logic             pixel_valid,
  input  logic             is_orange,
  output logic             orange_detected,
  output logic [DIR_W-1:0] direction,
  output logic [CNT_W-1:0] orange_count,
  output logic             result_valid,
  output logic             frame_error
);

  localparam int ZONE_W = WIDTH / NUM_ZONES;
  localparam int IDX_W  = width_bits(NUM_ZONES);
  localparam int COL_W  = width_bits(WIDTH + 1);
  localparam int LINE_W = width_bits(HEIGHT + 2);
  localparam int PROD_W = CNT_W + 7;
  localparam logic [PROD_W-1:0] PCT_SCALE  = PROD_W'(100);
  localparam logic [PROD_W-1:0] AREA_LIMIT = PROD_W'(THRESHOLD_PCT * WIDTH * HEIGHT);

  state_t                         state_r, state_next_s;
  logic                           vsync_d_r, href_d_r;
  logic                           vsync_rise_s, vsync_fall_s, href_fall_s;
  logic [COL_W-1:0]               col_r;
  logic [LINE_W-1:0]              line_r;
  logic [IDX_W-1:0]               zone_s;
  logic                           pixel_hit_s;
  logic [NUM_ZONES-1:0][CNT_W-1:0] zone_cnt_r;
  logic [CNT_W-1:0]               total_r;
  logic                           argmax_start_s, argmax_done_s, argmax_found_s;
  logic [IDX_W-1:0]               argmax_idx_s;
  logic [PROD_W-1:0]              scaled_total_s;
  logic                           above_s;

  assign vsync_rise_s = vsync && !vsync_d_r;
  assign vsync_fall_s = !vsync && vsync_d_r;
  assign href_fall_s  = !href && href_d_r;

  // Zone index = number of zone boundaries passed; the last zone absorbs the remainder.
  always_comb begin
    zone_s = '0;
    for (int z = 1; z < NUM_ZONES; z++) begin
      zone_s = zone_s + IDX_W'(col_r >= COL_W'(z * ZONE_W));
    end
  end

  assign pixel_hit_s = (state_r == ACTIVE) && href && pixel_valid && is_orange &&
                       (col_r < COL_W'(WIDTH)) && (line_r < LINE_W'(HEIGHT));

  assign scaled_total_s = PROD_W'(total_r) * PCT_SCALE;
  assign above_s        = scaled_total_s > AREA_LIMIT;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Next-state logic and argmax launch.
  always_comb begin
    state_next_s   = state_r;
    argmax_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (vsync_fall_s) state_next_s = ACTIVE;
        else              state_next_s = IDLE;
      end
      ACTIVE: begin
        if (vsync_rise_s) begin
          state_next_s   = REPORT;
          argmax_start_s = 1'b1;
        end else begin
          state_next_s   = ACTIVE;
        end
      end
      REPORT: begin
        if (argmax_done_s) state_next_s = PUBLISH;
        else               state_next_s = REPORT;
      end
      PUBLISH: state_next_s = WAIT;
      WAIT: begin
        if (vsync_fall_s) state_next_s = ACTIVE;
        else              state_next_s = WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Timing edge history plus column/line counters; the line count survives until PUBLISH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_d_r <= 1'b0;
      href_d_r  <= 1'b0;
      col_r     <= '0;
      line_r    <= '0;
    end else begin
      vsync_d_r <= vsync;
      href_d_r  <= href;
      case (state_r)
        ACTIVE: begin
          if (!href) col_r <= '0;
          else if (pixel_valid && (col_r < COL_W'(WIDTH))) col_r <= col_r + COL_W'(1);
          if (href_fall_s && (line_r < LINE_W'(HEIGHT + 1))) line_r <= line_r + LINE_W'(1);
        end
        REPORT, PUBLISH: col_r <= '0;
        default: begin
          col_r  <= '0;
          line_r <= '0;
        end
      endcase
    end
  end

  // Per-zone and total accumulators; cleared once results are captured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      zone_cnt_r <= '0;
      total_r    <= '0;
    end else begin
      case (state_r)
        ACTIVE: begin
          if (pixel_hit_s) begin
            zone_cnt_r[zone_s] <= zone_cnt_r[zone_s] + CNT_W'(1);
            total_r            <= total_r + CNT_W'(1);
          end
        end
        PUBLISH: begin
          zone_cnt_r <= '0;
          total_r    <= '0;
        end
        default: begin
          zone_cnt_r <= zone_cnt_r;
          total_r    <= total_r;
        end
      endcase
    end
  end

  zone_argmax #(
    .NUM_ZONES (NUM_ZONES),
    .CNT_W     (CNT_W)
  ) u_argmax (
    .clk     (clk),
    .resetn  (resetn),
    .start   (argmax_start_s),
    .counts  (zone_cnt_r),
    .done    (argmax_done_s),
    .found   (argmax_found_s),
    .max_idx (argmax_idx_s)
  );

`ifdef ORANGE_HYSTERESIS_EN
  logic [1:0] hist_r;
`endif

  // Published outputs; they hold between result_valid pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      orange_detected <= 1'b0;
      direction       <= '0;
      orange_count    <= '0;
      result_valid    <= 1'b0;
      frame_error     <= 1'b0;
`ifdef ORANGE_HYSTERESIS_EN
      hist_r          <= 2'b00;
`endif
    end else begin
      result_valid <= (state_r == PUBLISH);
      if (state_r == PUBLISH) begin
        direction    <= argmax_found_s ? (DIR_W'(argmax_idx_s) + DIR_W'(1)) : DIR_W'(DIR_NONE);
        orange_count <= total_r;
        frame_error  <= (line_r != LINE_W'(HEIGHT));
`ifdef ORANGE_HYSTERESIS_EN
        hist_r <= {hist_r[0], above_s};
        if (above_s && hist_r[0])        orange_detected <= 1'b1;
        else if (!above_s && !hist_r[0]) orange_detected <= 1'b0;
        else                             orange_detected <= orange_detected;
`else
        orange_detected <= above_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_orange_zone_classifier.sv
// Scoreboard bench for orange_zone_classifier on a reduced 40x24 frame, 3 zones, 25% threshold.
module tb_orange_zone_classifier;

  localparam int W   = 40;
  localparam int H   = 24;
  localparam int NZ  = 3;
  localparam int PCT = 25;
  localparam int CW  = 10;
  localparam int DW  = 2;

  logic          clk = 1'b0;
  logic          resetn, href, vsync, pixel_valid, is_orange;
  logic          orange_detected, result_valid, frame_error;
  logic [DW-1:0] direction;
  logic [CW-1:0] orange_count;

  typedef struct {
    int dir;
    int cnt;
    int det;
    int err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0, bad = 0, cyc = 0, rise_cyc = 0, results = 0;
  int   m_prev = 0, m_det = 0;

  orange_zone_classifier #(
    .WIDTH(W), .HEIGHT(H), .NUM_ZONES(NZ), .THRESHOLD_PCT(PCT)
  ) dut (
    .clk(clk), .resetn(resetn), .href(href), .vsync(vsync),
    .pixel_valid(pixel_valid), .is_orange(is_orange),
    .orange_detected(orange_detected), .direction(direction),
    .orange_count(orange_count), .result_valid(result_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every result pulse pops one expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("direction", direction, mon_e.dir);
        check("orange_count", orange_count, mon_e.cnt);
        check("orange_detected", orange_detected, mon_e.det);
        check("frame_error", frame_error, mon_e.err);
        check("latency", cyc - rise_cyc, 5);
      end
      results++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input int dir, input int cnt, input int err);
    exp_t e;
    int above;
    above = (cnt * 100 > PCT * W * H) ? 1 : 0;
`ifdef ORANGE_HYSTERESIS_EN
    if (above == 1 && m_prev == 1)      m_det = 1;
    else if (above == 0 && m_prev == 0) m_det = 0;
    m_prev = above;
`else
    m_det = above;
`endif
    e.dir = dir; e.cnt = cnt; e.det = m_det; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic run_frame(input int nlines,
                           input int a_lo, input int a_hi, input int a_lines,
                           input int b_lo, input int b_hi, input int b_lines,
                           input int dir, input int cnt, input int err);
    int n0;
    vsync = 1'b0;
    step(); step();
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < W; c++) begin
        href        = 1'b1;
        pixel_valid = 1'b1;
        is_orange   = ((c >= a_lo && c <= a_hi && l < a_lines) ||
                       (c >= b_lo && c <= b_hi && l < b_lines));
        step();
      end
      href = 1'b0; pixel_valid = 1'b0; is_orange = 1'b0;
      repeat (3) step();
    end
    expect_frame(dir, cnt, err);
    vsync    = 1'b1;
    rise_cyc = cyc;
    n0       = results;
    for (int i = 0; i < 20 && results == n0; i++) step();
    if (results == n0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: actual=0 required=1");
    end
    repeat (3) step();
  endtask

  initial begin
    resetn = 1'b0; href = 1'b0; vsync = 1'b1; pixel_valid = 1'b0; is_orange = 1'b0;
    repeat (3) step();
    check("reset_direction", direction, 0);
    check("reset_count", orange_count, 0);
    check("reset_detected", orange_detected, 0);
    check("reset_error", frame_error, 0);
    check("reset_valid", result_valid, 0);
    resetn = 1'b1;
    repeat (10) step();
    check("idle_no_valid", result_valid, 0);

    run_frame(H,  0,  4, H,  1,  0, 0,  1, 120, 0);   // zone 0 stripe, below threshold
    run_frame(H, 26, 39, H,  1,  0, 0,  3, 336, 0);   // last zone incl. remainder columns
    run_frame(H,  0,  9, 1, 13, 22, 1,  1,  20, 0);   // tie between zones 0 and 1
    run_frame(H,  1,  0, 0,  1,  0, 0,  0,   0, 0);   // all black
    run_frame(H,  0,  9, H,  1,  0, 0,  1, 240, 0);   // exactly at threshold
    run_frame(H,  0,  9, H, 10, 10, 1,  1, 241, 0);   // one pixel over threshold
    run_frame(10, 0,  4, H,  1,  0, 0,  1,  50, 1);   // short frame
    run_frame(30, 13, 25, 30, 1,  0, 0,  2, 312, 1);  // long frame, extra lines ignored

    // Reset in the middle of a frame discards it.
    vsync = 1'b0;
    step(); step();
    href = 1'b1; pixel_valid = 1'b1; is_orange = 1'b1;
    repeat (3 * W + 5) step();
    resetn = 1'b0;
    m_prev = 0; m_det = 0;
    step();
    check("midreset_direction", direction, 0);
    check("midreset_count", orange_count, 0);
    check("midreset_detected", orange_detected, 0);
    check("midreset_error", frame_error, 0);
    check("midreset_valid", result_valid, 0);
    href = 1'b0; pixel_valid = 1'b0; is_orange = 1'b0; vsync = 1'b1;
    step();
    resetn = 1'b1;
    repeat (4) step();
    run_frame(H, 26, 27, H, 1, 0, 0, 3, 48, 0);

    // Over, under, over, over sequence exercises detection history.
    run_frame(H, 26, 39, H, 1, 0, 0, 3, 336, 0);
    run_frame(H,  1,  0, 0, 1, 0, 0, 0,   0, 0);
    run_frame(H, 26, 39, H, 1, 0, 0, 3, 336, 0);
    run_frame(H, 26, 39, H, 1, 0, 0, 3, 336, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/orange_zone_classifier.md
# orange_zone_classifier

- Frame-level classifier for the camera pipeline; sits after the per-pixel orange detector, consuming its `is_orange` flag alongside the camera line/frame timing.
- Accumulates orange pixels per vertical zone over a whole frame and applies an area threshold.
- Once per frame, publishes a steering direction (winning zone), a total count and a detection flag to the control logic.

## Interface
Parameters:
- `WIDTH`, 320: active pixels per line.
- `HEIGHT`, 240: active lines per frame.
- `NUM_ZONES`, 3: horizontal zones. Must satisfy 2 ≤ `NUM_ZONES` ≤ 8.
- `THRESHOLD_PCT`, 25: percentage of frame area required for detection.

Ports:
- `clk`  in  1  pixel clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `href`  in  1  line active.
- `vsync`  in  1  frame sync; its rising edge marks end of frame.
- `pixel_valid`  in  1  pixel strobe, qualified by `href`.
- `is_orange`  in  1  classification of the current pixel.
- `orange_detected`  out  1  frame area above threshold.
- `direction`  out  `DIR_W`  0 = no orange; z+1 = zone z wins. `DIR_W` = $clog2(`NUM_ZONES`+1).
- `orange_count`  out  `CNT_W`  total orange pixels in the last frame. `CNT_W` = $clog2(`WIDTH`*`HEIGHT`+1).
- `result_valid`  out  1  one-cycle pulse when outputs update.
- `frame_error`  out  1  last frame's line count ≠ `HEIGHT`.

## Operation
- Reset: all outputs 0; all counters 0; state IDLE.
- Zone geometry:
  - `ZONE_W` = `WIDTH`/`NUM_ZONES`.
  - zone = min(col/`ZONE_W`, `NUM_ZONES`-1); the last zone absorbs the remainder.
- Column counter:
  - increments on each `pixel_valid`&&`href`; clears when `href` is low.
  - Columns ≥ `WIDTH` are not counted.
- Line counter: increments on each `href` falling edge; saturates at `HEIGHT`+1.
  - Lines beyond `HEIGHT` are not counted.
- State machine:
  - IDLE → ACTIVE on the first `vsync` falling edge.
  - ACTIVE: per-zone accumulators (`CNT_W` bits each) and the total increment when `is_orange` is set on a counted pixel.
  - ACTIVE → REPORT on a `vsync` rising edge.
  - REPORT: sequential argmax, one zone per cycle, `NUM_ZONES` cycles.
    - Strict greater-than comparison, so ties go to the lowest zone index.
    - All-zero counts → `direction` = 0.
  - REPORT → PUBLISH: register the outputs, pulse `result_valid`, clear the accumulators, then → WAIT.
  - WAIT → ACTIVE on a `vsync` falling edge.
- Threshold: `orange_detected` = (total*100 > `THRESHOLD_PCT`*`WIDTH`*`HEIGHT`).
  - Computed in a `CNT_W`+7-bit width; no truncation.
- `frame_error`: set at PUBLISH when the line count ≠ `HEIGHT`.
  - Covers short frames (early `vsync`) and long frames; results are still published.
- `href`/pixels seen during REPORT/PUBLISH/WAIT are ignored. They do not count toward the next frame.
- Outputs hold between `result_valid` pulses.

## Timing
- `vsync` is edge-detected with a one-cycle registered history.
- An edge sampled high at cycle k enters REPORT at k+1.
- PUBLISH occurs at k+1+`NUM_ZONES`; outputs and `result_valid` are visible at k+2+`NUM_ZONES`. With defaults that is 5 cycles after the edge.
- Pixel-to-accumulator latency: 1 cycle. A pixel on the same cycle as the `vsync` rising edge is still counted.
- `resetn` asserted mid-frame: immediate return to IDLE with outputs zeroed. The partial frame is discarded.

## Configuration
- `ORANGE_HYSTERESIS_EN` defined:
  - `orange_detected` sets only after 2 consecutive frames above threshold.
  - It clears only after 2 consecutive frames at or below threshold.
  - Adds a 2-bit frame-history register, reset to 0.
- Undefined: `orange_detected` reflects the current frame only.
- `direction` and `orange_count` are unaffected either way.

## Structure
- Package `orange_pkg`:
  - state enum (IDLE, ACTIVE, REPORT, PUBLISH, WAIT);
  - `DIR_NONE` = 0 constant;
  - a width helper function for `CNT_W`/`DIR_W`.
- Sub-module `zone_argmax`:
  - sequential max-finder over `NUM_ZONES` counts;
  - start/done handshake; holds the running max and index.

## Test plan
- Reset held, then released → all outputs 0, no `result_valid` until a full frame completes.
- Full 320×240 frame, orange only at columns 0–49 on all lines → `direction`=1, `orange_count`=12000, `orange_detected`=0, `frame_error`=0. `result_valid` arrives 5 cycles after the `vsync` rise.
- Orange at columns 212–319 on every line → `orange_count`=25920, `direction`=3, `orange_detected`=1 (25920 > 19200).
- 10 orange pixels each in zones 0 and 1 → `direction`=1 (tie goes to lowest index). All-black frame → `direction`=0.
- `vsync` rises after 100 lines → `frame_error`=1 with results published. `resetn` pulsed mid-frame → outputs 0 and the next frame counts cleanly.
- With `ORANGE_HYSTERESIS_EN`: frames over, under, over, over threshold → `orange_detected` 0, 0, 0, 1.
